// File: rtl/data_memory_arbiter_if.sv
// Requester-side bundle for one data_memory_arbiter port: request fields in,
// grant / error / read-response out.
interface data_memory_arbiter_if;
    logic        req;
    logic [31:0] address;
    logic [31:0] data;
    logic        wren;
    logic [1:0]  mem_mode;
    logic        is_unsigned;
    logic        gnt;
    logic        rvalid;
    logic [31:0] q;
    logic        err;

    modport master (
        output req, address, data, wren, mem_mode, is_unsigned,
        input  gnt, rvalid, q, err
    );

    modport slave (
        input  req, address, data, wren, mem_mode, is_unsigned,
        output gnt, rvalid, q, err
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one data_memory port between the core LSU (p0)
// and the debug loader (p1); loads own the memory until their data returns.
module data_memory_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    data_memory_arbiter_if.slave          p0,
    data_memory_arbiter_if.slave          p1,
    output logic [31:0]                   mem_address,
    output logic [31:0]                   mem_data,
    output logic                          mem_wren,
    output logic [1:0]                    mem_mode,
    output logic                          mem_unsigned,
    input  logic [31:0]                   mem_q
);

    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_next;
    logic [2:0]  count, count_next;
    logic        last_grant, last_grant_next;
    logic        owner, owner_next;
    logic [31:0] hold_address;
    logic [1:0]  hold_mode;
    logic        hold_unsigned;

    logic        any_req;
    logic        winner;
    logic [31:0] w_address;
    logic [31:0] w_data;
    logic        w_wren;
    logic [1:0]  w_mode;
    logic        w_unsigned;
    logic        misaligned;
    logic [1:0]  gnt;
    logic [1:0]  err;
    logic [1:0]  rvalid;

    // On a tie the port that did not win last time gets the memory.
    assign any_req    = p0.req | p1.req;
    assign winner     = (p0.req && p1.req) ? ~last_grant : p1.req;
    assign w_address  = winner ? p1.address     : p0.address;
    assign w_data     = winner ? p1.data        : p0.data;
    assign w_wren     = winner ? p1.wren        : p0.wren;
    assign w_mode     = winner ? p1.mem_mode    : p0.mem_mode;
    assign w_unsigned = winner ? p1.is_unsigned : p0.is_unsigned;
    assign misaligned = ((w_mode == MEM_HALF) && (w_address[1:0] == 2'b11)) ||
                        ((w_mode == MEM_WORD) && (w_address[1:0] != 2'b00));

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path leaves a latch.
        state_next      = state;
        count_next      = count;
        last_grant_next = last_grant;
        owner_next      = owner;
        gnt             = 2'b00;
        err             = 2'b00;
        rvalid          = 2'b00;
        mem_address     = '0;
        mem_data        = '0;
        mem_wren        = 1'b0;
        mem_mode        = 2'd0;
        mem_unsigned    = 1'b0;

        // Outputs are gated by the asynchronous reset so they drop immediately.
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt[winner]     = 1'b1;
                        last_grant_next = winner;
                        mem_address     = w_address;
                        mem_data        = w_data;
                        mem_mode        = w_mode;
                        mem_unsigned    = w_unsigned;
                        if (misaligned) begin
                            err[winner] = 1'b1;
                        end else if (w_wren) begin
                            mem_wren = 1'b1;
                        end else begin
                            state_next = WAIT;
                            count_next = READ_LATENCY[2:0];
                            owner_next = winner;
                        end
                    end
                end
                WAIT: begin
                    mem_address  = hold_address;
                    mem_mode     = hold_mode;
                    mem_unsigned = hold_unsigned;
                    count_next   = count - 3'd1;
                    if (count == 3'd1) begin
                        rvalid[owner] = 1'b1;
                        state_next    = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state         <= IDLE;
            count         <= 3'd0;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            hold_address  <= '0;
            hold_mode     <= 2'd0;
            hold_unsigned <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            last_grant <= last_grant_next;
            owner      <= owner_next;
            if (state == IDLE && state_next == WAIT) begin
                hold_address  <= mem_address;
                hold_mode     <= mem_mode;
                hold_unsigned <= mem_unsigned;
            end
        end
    end

    assign p0.gnt    = gnt[0];
    assign p1.gnt    = gnt[1];
    assign p0.err    = err[0];
    assign p1.err    = err[1];
    assign p0.rvalid = rvalid[0];
    assign p1.rvalid = rvalid[1];
    assign p0.q      = mem_q;
    assign p1.q      = mem_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: randomized traffic on both ports
// against a transaction-level model, plus reset and tie-break scenarios.
module tb_data_memory_arbiter;

    localparam int L = 3;
    localparam logic [1:0] M_BYTE = 2'd0;
    localparam logic [1:0] M_HALF = 2'd1;
    localparam logic [1:0] M_WORD = 2'd2;

    typedef struct {
        logic        err;
        logic        load;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  mode;
        logic        uns;
    } exp_t;

    typedef struct {
        int          port;
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } pend_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    data_memory_arbiter_if p0();
    data_memory_arbiter_if p1();

    logic [31:0] mem_address, mem_data, mem_q;
    logic        mem_wren, mem_unsigned;
    logic [1:0]  mem_mode;

    data_memory_arbiter #(.READ_LATENCY(L)) dut (
        .clock        (clock),
        .reset        (reset),
        .p0           (p0),
        .p1           (p1),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .mem_mode     (mem_mode),
        .mem_unsigned (mem_unsigned),
        .mem_q        (mem_q)
    );

    logic        drv_req  [2] = '{1'b0, 1'b0};
    logic [31:0] drv_addr [2] = '{32'h0, 32'h0};
    logic [31:0] drv_data [2] = '{32'h0, 32'h0};
    logic        drv_wren [2] = '{1'b0, 1'b0};
    logic [1:0]  drv_mode [2] = '{2'd0, 2'd0};
    logic        drv_uns  [2] = '{1'b0, 1'b0};

    assign p0.req = drv_req[0];  assign p1.req = drv_req[1];
    assign p0.address = drv_addr[0];  assign p1.address = drv_addr[1];
    assign p0.data = drv_data[0];  assign p1.data = drv_data[1];
    assign p0.wren = drv_wren[0];  assign p1.wren = drv_wren[1];
    assign p0.mem_mode = drv_mode[0];  assign p1.mem_mode = drv_mode[1];
    assign p0.is_unsigned = drv_uns[0];  assign p1.is_unsigned = drv_uns[1];

    // Behavioural data memory: word array plus an L-stage read pipeline.
    logic [31:0] tb_mem [256] = '{default: 32'h0};
    logic [31:0] pipe [L] = '{default: 32'h0};
    always @(posedge clock) begin
        if (mem_wren) tb_mem[mem_address[9:2]] <= mem_data;
        pipe[0] <= tb_mem[mem_address[9:2]];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_q = pipe[L-1];

    logic [31:0] model_mem [256] = '{default: 32'h0};
    exp_t  exp_q0[$];
    exp_t  exp_q1[$];
    pend_t pend_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic last_w = 1'b1;
    int busy_end = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the expected transaction on each grant and the pending load on each rvalid.
    always @(negedge clock) begin
        logic [1:0] eg, ee, er;
        exp_t       e;
        pend_t      pd;
        int         w;
        bit         busy;
        if (mon_en) begin
            eg = 2'b00; ee = 2'b00; er = 2'b00;
            busy = (cyc <= busy_end);
            if (!busy && (drv_req[0] || drv_req[1])) begin
                if (drv_req[0] && drv_req[1]) w = last_w ? 0 : 1;
                else                          w = drv_req[1] ? 1 : 0;
                eg[w] = 1'b1;
                last_w = w[0];
                e = (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (e.err) ee[w] = 1'b1;
                check("mem_wren", {31'b0, mem_wren}, {31'b0, !e.err && !e.load});
                check("mem_address", mem_address, e.addr);
                if (!e.err && !e.load) check("mem_data", mem_data, e.data);
                if (!e.err) begin
                    check("mem_mode", {30'b0, mem_mode}, {30'b0, e.mode});
                    check("mem_unsigned", {31'b0, mem_unsigned}, {31'b0, e.uns});
                end
                if (!e.err && e.load) begin
                    pd.port = w; pd.due = cyc + L; pd.addr = e.addr; pd.data = e.data;
                    pend_q.push_back(pd);
                    busy_end = cyc + L;
                end
            end else if (busy) begin
                check("mem_wren_wait", {31'b0, mem_wren}, 32'h0);
                if (pend_q.size() != 0) check("mem_address_wait", mem_address, pend_q[0].addr);
            end else begin
                check("mem_wren_idle", {31'b0, mem_wren}, 32'h0);
                check("mem_address_idle", mem_address, 32'h0);
            end
            check("gnt", {30'b0, p1.gnt, p0.gnt}, {30'b0, eg});
            check("err", {30'b0, p1.err, p0.err}, {30'b0, ee});
            if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                er[pend_q[0].port] = 1'b1;
                check("q", (pend_q[0].port == 0) ? p0.q : p1.q, pend_q[0].data);
                void'(pend_q.pop_front());
            end
            check("rvalid", {30'b0, p1.rvalid, p0.rvalid}, {30'b0, er});
        end
    end

    task automatic do_txn(input int n, input logic [31:0] addr, input logic [31:0] data,
                          input logic wren, input logic [1:0] mode, input logic uns);
        exp_t e;
        bit   got;
        e.err  = ((mode == M_HALF) && (addr[1:0] == 2'b11)) ||
                 ((mode == M_WORD) && (addr[1:0] != 2'b00));
        e.load = !wren;
        e.addr = addr;
        e.data = wren ? data : model_mem[addr[9:2]];
        e.mode = mode;
        e.uns  = uns;
        if (wren && !e.err) model_mem[addr[9:2]] = data;
        if (n == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        drv_addr[n] = addr; drv_data[n] = data; drv_wren[n] = wren;
        drv_mode[n] = mode; drv_uns[n] = uns; drv_req[n] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if ((n == 0) ? p0.gnt : p1.gnt) begin
                got = 1'b1;
                break;
            end
        end
        check("gnt_wait", {31'b0, got}, 32'h1);
        if (!got) begin
            if (n == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
        end
        @(posedge clock); #1;
        drv_req[n] = 1'b0;
    endtask

    task automatic rand_port(input int n, input int count);
        logic [31:0] a;
        int          gap;
        for (int k = 0; k < count; k++) begin
            a   = 32'(n * 256) + 32'($urandom_range(0, 255));
            gap = $urandom_range(0, 2);
            do_txn(n, a, $urandom, 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            repeat (gap) begin @(posedge clock); #1; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        // Requests raised while in reset must not produce any grant.
        drv_req[0] = 1'b1; drv_req[1] = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", {28'b0, p0.gnt | p1.gnt, p0.rvalid | p1.rvalid, p0.err | p1.err, mem_wren}, 32'h0);
        drv_req[0] = 1'b0; drv_req[1] = 1'b0;
        @(negedge clock);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(posedge clock); #1;

        do_txn(0, 32'h10, 32'hDEADBEEF, 1'b1, M_WORD, 1'b0);
        do_txn(0, 32'h10, 32'h0, 1'b0, M_WORD, 1'b0);
        do_txn(1, 32'h3, 32'hAAAA5555, 1'b1, M_HALF, 1'b0);
        do_txn(1, 32'h0, 32'h0, 1'b0, M_WORD, 1'b0);
        do_txn(1, 32'h2, 32'hBBBB6666, 1'b1, M_WORD, 1'b0);
        do_txn(1, 32'h2, 32'h12345678, 1'b1, M_HALF, 1'b0);
        do_txn(1, 32'h0, 32'h0, 1'b0, M_WORD, 1'b1);
        do_txn(0, 32'h7, 32'h0, 1'b0, M_BYTE, 1'b1);

        fork
            rand_port(0, 150);
            rand_port(1, 150);
        join
        repeat (L + 3) begin @(posedge clock); #1; end
        check("exp_q_drained", 32'(exp_q0.size() + exp_q1.size() + pend_q.size()), 32'h0);
        mon_en = 1'b0;

        // Reset in the grant cycle of a load drops the load entirely.
        drv_addr[0] = 32'h20; drv_wren[0] = 1'b0; drv_mode[0] = M_WORD; drv_req[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (p0.gnt) begin got = 1'b1; break; end
        end
        check("t5_gnt", {31'b0, got}, 32'h1);
        #2 reset = 1'b0;
        #1 check("t5_rst_out", {28'b0, p0.gnt | p1.gnt, p0.rvalid | p1.rvalid, p0.err | p1.err, mem_wren}, 32'h0);
        drv_req[0] = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("t5_rvalid_in_reset", {30'b0, p1.rvalid, p0.rvalid}, 32'h0);
        end
        reset = 1'b1;
        for (int i = 0; i < L + 3; i++) begin
            @(negedge clock);
            check("t5_no_rvalid", {30'b0, p1.rvalid, p0.rvalid}, 32'h0);
            check("t5_idle_wren", {31'b0, mem_wren}, 32'h0);
        end
        @(posedge clock); #1;
        drv_addr[0] = 32'h24; drv_wren[0] = 1'b0; drv_mode[0] = M_WORD; drv_req[0] = 1'b1;
        drv_addr[1] = 32'h124; drv_wren[1] = 1'b0; drv_mode[1] = M_WORD; drv_req[1] = 1'b1;
        @(negedge clock);
        check("t5_tie_after_reset", {30'b0, p1.gnt, p0.gnt}, 32'h1);
        @(posedge clock); #1;
        drv_req[0] = 1'b0; drv_req[1] = 1'b0;
        repeat (L + 2) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
